// File: rtl/ysyx_22040386_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the NPC 32x64 register file.
// Optional decode forwarding of the in-flight write: define YSYX_22040386_WB_FWD_EN.
module ysyx_22040386_wb_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [31:0]           busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  fwd1_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd2_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt;
  logic                  starve_hit;
  logic                  alu_xfer;
  logic                  lsu_xfer;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic [31:0]           busy_next;

  // Ready depends only on the valids and the counter, never on address or data.
  assign starve_hit = (starve_cnt == LIMIT);
  assign alu_ready  = alu_valid && (!lsu_valid || starve_hit);
  assign lsu_ready  = lsu_valid && !(alu_valid && starve_hit);
  assign alu_xfer   = alu_valid && alu_ready;
  assign lsu_xfer   = lsu_valid && lsu_ready;
  assign win_addr   = alu_xfer ? alu_addr : lsu_addr;
  assign win_data   = alu_xfer ? alu_data : lsu_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_xfer) begin
      starve_cnt <= '0;
    end else if (alu_valid && !starve_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= (alu_xfer || lsu_xfer) && (win_addr != '0);
      if (alu_xfer || lsu_xfer) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
    end
  end

  // NOTE: default every combinational output first so no path infers a latch.
  always_comb begin
    busy_next = busy;
    if (rf_wen) busy_next[rf_waddr] = 1'b0;
    // A new reservation supersedes the committing producer of the same register.
    if (rsv_valid && (rsv_addr != '0)) busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

`ifdef YSYX_22040386_WB_FWD_EN
  assign fwd1_hit  = rf_wen && (raddr1 == rf_waddr);
  assign fwd2_hit  = rf_wen && (raddr2 == rf_waddr);
  assign fwd1_data = fwd1_hit ? rf_wdata : '0;
  assign fwd2_data = fwd2_hit ? rf_wdata : '0;
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule
